// File: rtl/sbox_word_sequencer_pkg.sv
// sbox_word_sequencer_pkg: shared state encoding, tag type and lane mapping
// used by the S-box word sequencer and its tag delay line.
package sbox_word_sequencer_pkg;

    localparam int unsigned WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FEED = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } seq_state_t;

    // Travels alongside each issued byte so the returning S-box output
    // knows which result lane it belongs to.
    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } seq_tag_t;

    // Input lane fed to the S-box for result lane idx; rot selects the
    // RotWord ordering (lane k takes input byte k+1 mod 4).
    function automatic logic [1:0] src_lane(input logic [1:0] idx, input logic rot);
        return idx + {1'b0, rot};
    endfunction

endpackage

// File: rtl/sbox_word_sequencer_if.sv
// sbox_word_sequencer_if: word-level valid/ready input and output channels.
interface sbox_word_sequencer_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_word;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;

    modport slave (
        input  in_valid, in_word, out_ready,
        output in_ready, out_valid, out_word
    );

    modport master (
        output in_valid, in_word, out_ready,
        input  in_ready, out_valid, out_word
    );

endinterface

// File: rtl/sbox_word_sequencer_tag_pipe.sv
// sbox_seq_tag_pipe: SBOX_LAT-deep delay line that keeps byte tags aligned
// with the external S-box pipeline. Asynchronous reset flushes every stage.
module sbox_seq_tag_pipe
    import sbox_word_sequencer_pkg::*;
#(
    parameter int unsigned SBOX_LAT = 1
) (
    input  logic     clk,
    input  logic     rst,
    input  seq_tag_t tag_in,
    output seq_tag_t tag_out
);

    generate
        if (SBOX_LAT == 0) begin : g_comb
            assign tag_out = tag_in;
        end else begin : g_pipe
            seq_tag_t stage [SBOX_LAT];

            // Shift tags one stage per cycle; reset empties the line.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int unsigned i = 0; i < SBOX_LAT; i++) begin
                        stage[i] <= '0;
                    end
                end else begin
                    stage[0] <= tag_in;
                    for (int unsigned i = 1; i < SBOX_LAT; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign tag_out = stage[SBOX_LAT-1];
        end
    endgenerate

endmodule

// File: rtl/sbox_word_sequencer.sv
// sbox_word_sequencer: serialises a 32-bit word through a byte-wide external
// S-box and reassembles the substituted word.
// Optional macro SBOX_SEQ_ROTWORD_EN adds rot_en (RotWord before SubWord).
module sbox_word_sequencer
    import sbox_word_sequencer_pkg::*;
#(
    parameter int unsigned SBOX_LAT = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    sbox_word_sequencer_if.slave        bus,
`ifdef SBOX_SEQ_ROTWORD_EN
    input  logic                        rot_en,
`endif
    output logic                        sbox_en,
    output logic [7:0]                  sbox_byte_o,
    input  logic [7:0]                  sbox_byte_i
);

    localparam int unsigned WORD_W = WORD_BYTES * 8;

    seq_state_t         state;
    logic [1:0]         cnt;
    logic [WORD_W-1:0]  in_reg;
    logic [WORD_W-1:0]  result;
    logic [WORD_W-1:0]  result_next;
    logic               rot_q;
    logic               rot_now;
    logic               last_collect;
    seq_tag_t           tag_in;
    seq_tag_t           tag_out;

`ifdef SBOX_SEQ_ROTWORD_EN
    assign rot_now = rot_en;
`else
    assign rot_now = 1'b0;
`endif

    // The tag for the byte currently on sbox_byte_o; idx is the result lane.
    assign tag_in = '{valid: sbox_en, idx: cnt};

    sbox_seq_tag_pipe #(
        .SBOX_LAT (SBOX_LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    // Merge the returning S-box byte into its lane; lane 3 completes the word.
    always_comb begin
        result_next = result;
        if (tag_out.valid) begin
            result_next[{tag_out.idx, 3'b000} +: 8] = sbox_byte_i;
        end
        last_collect = tag_out.valid && (tag_out.idx == 2'd3);
    end

    // Control FSM; outputs are registered and reflect the next state, so the
    // first byte leaves on the acceptance edge and out_valid rises on the
    // same edge that collects lane 3.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            in_reg        <= '0;
            rot_q         <= 1'b0;
            result        <= '0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_word  <= '0;
            sbox_en       <= 1'b0;
            sbox_byte_o   <= '0;
        end else begin
            result <= result_next;
            case (state)
                IDLE: begin
                    if (bus.in_valid && bus.in_ready) begin
                        in_reg       <= bus.in_word;
                        rot_q        <= rot_now;
                        cnt          <= '0;
                        sbox_byte_o  <= bus.in_word[{src_lane(2'd0, rot_now), 3'b000} +: 8];
                        sbox_en      <= 1'b1;
                        bus.in_ready <= 1'b0;
                        state        <= FEED;
                    end
                end
                FEED, WAIT: begin
                    if (state == FEED) begin
                        if (cnt == 2'd3) begin
                            sbox_en <= 1'b0;
                            state   <= WAIT;
                        end else begin
                            cnt         <= cnt + 2'd1;
                            sbox_byte_o <= in_reg[{src_lane(cnt + 2'd1, rot_q), 3'b000} +: 8];
                        end
                    end
                    // With a combinational S-box lane 3 returns while still in FEED.
                    if (last_collect) begin
                        state         <= DONE;
                        bus.out_valid <= 1'b1;
                        bus.out_word  <= result_next;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sbox_word_sequencer.sv
// tb_sbox_word_sequencer: scoreboard bench for sbox_word_sequencer with a
// forward AES S-box model of configurable latency.
// Optional macro SBOX_SEQ_ROTWORD_EN enables the RotWord scenario.
module tb_sbox_word_sequencer;

    parameter int unsigned LAT = 1;
    localparam int unsigned TAP = (LAT == 0) ? 0 : LAT - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sbox_en;
    logic [7:0]  sbox_byte_o;
    logic [7:0]  sbox_byte_i;
`ifdef SBOX_SEQ_ROTWORD_EN
    logic        rot_en;
`endif

    sbox_word_sequencer_if bus ();

    sbox_word_sequencer #(
        .SBOX_LAT (LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
`ifdef SBOX_SEQ_ROTWORD_EN
        .rot_en      (rot_en),
`endif
        .sbox_en     (sbox_en),
        .sbox_byte_o (sbox_byte_o),
        .sbox_byte_i (sbox_byte_i)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    // Forward AES S-box: inverse as x^254, then the affine transform.
    function automatic logic [7:0] sbox_ref(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] w, input logic rot);
        logic [31:0] r;
        int          j;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            j = (k + (rot ? 1 : 0)) % 4;
            r[8*k +: 8] = sbox_ref(w[8*j +: 8]);
        end
        return r;
    endfunction

    // External S-box model: LAT register stages, or combinational for LAT=0.
    logic [7:0] sb_pipe [8];
    always @(posedge clk) begin
        sb_pipe[0] <= sbox_ref(sbox_byte_o);
        for (int i = 1; i < 8; i++) sb_pipe[i] <= sb_pipe[i-1];
    end
    always_comb sbox_byte_i = (LAT == 0) ? sbox_ref(sbox_byte_o) : sb_pipe[TAP];

    logic [31:0] exp_q [$];
    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned hs_edge = 0;

    // Scoreboard: pop and compare on every output handshake.
    always @(negedge clk) begin
        logic [31:0] exp;
        #1;
        if (!rst && bus.out_valid && bus.out_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL out_word_unexpected: got %h, required no output", bus.out_word);
            end else begin
                exp = exp_q.pop_front();
                if (bus.out_word !== exp) begin
                    miscompares++;
                    $display("FAIL out_word: got %h, required %h", bus.out_word, exp);
                end
            end
        end
    end

    // Present a word and return at the negedge after its acceptance edge.
    task automatic send_word(input logic [31:0] w, input logic rot, input bit keep_valid);
        int unsigned n = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_word  = w;
`ifdef SBOX_SEQ_ROTWORD_EN
        rot_en = rot;
`endif
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            vectors++; miscompares++;
            $display("FAIL accept_timeout: in_ready=%b, required 1", bus.in_ready);
            bus.in_valid = 1'b0;
            return;
        end
        exp_q.push_back(exp_word(w, rot));
        @(negedge clk);
        hs_edge = cyc;
        if (!keep_valid) bus.in_valid = 1'b0;
        bus.in_word = ~w;
`ifdef SBOX_SEQ_ROTWORD_EN
        rot_en = ~rot;
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors += 5;
        if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready: got %b, required 1", bus.in_ready); end
        if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %b, required 0", bus.out_valid); end
        if (bus.out_word !== 32'h0) begin miscompares++; $display("FAIL rst_out_word: got %h, required 0", bus.out_word); end
        if (sbox_en !== 1'b0) begin miscompares++; $display("FAIL rst_sbox_en: got %b, required 0", sbox_en); end
        if (sbox_byte_o !== 8'h0) begin miscompares++; $display("FAIL rst_sbox_byte_o: got %h, required 0", sbox_byte_o); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [31:0] w = 32'h5301_00FF;
        int unsigned n = 0, en_cnt = 0;
        bus.out_ready = 1'b1;
        send_word(w, 1'b0, 1'b0);
        while (!bus.out_valid && n < 60) begin
            if (sbox_en) begin
                vectors++;
                if (sbox_byte_o !== w[8*en_cnt +: 8]) begin
                    miscompares++;
                    $display("FAIL issue_byte%0d: got %h, required %h", en_cnt, sbox_byte_o, w[8*en_cnt +: 8]);
                end
                en_cnt++;
            end
            @(negedge clk);
            n++;
        end
        vectors += 3;
        if (cyc + 1 - hs_edge !== 5 + LAT) begin
            miscompares++; $display("FAIL basic_rise: out_valid at cycle %0d, required %0d", cyc + 1 - hs_edge, 5 + LAT);
        end
        if (en_cnt !== 4) begin
            miscompares++; $display("FAIL basic_sbox_en_cycles: got %0d, required 4", en_cnt);
        end
        if (bus.out_word !== 32'hED7C6316) begin
            miscompares++; $display("FAIL basic_word: got %h, required ed7c6316", bus.out_word);
        end
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin @(negedge clk); n++; end
    endtask

`ifdef SBOX_SEQ_ROTWORD_EN
    task automatic test_rotword();
        int unsigned n = 0;
        bus.out_ready = 1'b1;
        send_word(32'h5301_00FF, 1'b1, 1'b0);
        while (!bus.out_valid && n < 60) begin @(negedge clk); n++; end
        vectors++;
        if (bus.out_word !== 32'h16ED7C63) begin
            miscompares++; $display("FAIL rot_word: got %h, required 16ed7c63", bus.out_word);
        end
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin @(negedge clk); n++; end
    endtask
`endif

    task automatic test_hold();
        int unsigned n = 0;
        bus.out_ready = 1'b0;
        send_word(32'h0, 1'b0, 1'b0);
        while (!bus.out_valid && n < 60) begin @(negedge clk); n++; end
        bus.in_valid = 1'b1;
        bus.in_word  = 32'h1234_5678;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vectors += 4;
            if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL hold_out_valid: got %b, required 1", bus.out_valid); end
            if (bus.out_word !== 32'h63636363) begin miscompares++; $display("FAIL hold_out_word: got %h, required 63636363", bus.out_word); end
            if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL hold_in_ready: got %b, required 0", bus.in_ready); end
            if (sbox_en !== 1'b0) begin miscompares++; $display("FAIL hold_sbox_en: got %b, required 0", sbox_en); end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int unsigned n = 0, e1, e2 = 0, o1 = 0;
        bus.out_ready = 1'b1;
        send_word(32'h0101_0101, 1'b0, 1'b1);
        e1 = hs_edge;
        bus.in_word = 32'hFFFF_FFFF;
        while (n < 60) begin
            if (bus.out_valid && o1 == 0) o1 = cyc + 1;
            if (bus.in_ready) break;
            @(negedge clk);
            n++;
        end
        vectors += 2;
        if (!bus.in_ready) begin
            miscompares++; $display("FAIL b2b_accept_timeout: in_ready=%b, required 1", bus.in_ready);
        end else begin
            e2 = cyc + 1;
            exp_q.push_back(exp_word(32'hFFFF_FFFF, 1'b0));
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        if (e2 !== o1 + 1) begin
            miscompares++; $display("FAIL b2b_reaccept: accept edge %0d, required %0d", e2, o1 + 1);
        end
        if (e2 - e1 !== 6 + LAT) begin
            miscompares++; $display("FAIL b2b_period: got %0d, required %0d", e2 - e1, 6 + LAT);
        end
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin @(negedge clk); n++; end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++; $display("FAIL b2b_drain: %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int unsigned n = 0;
        bus.out_ready = 1'b1;
        send_word(32'hA1B2_C3D4, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        exp_q.delete();
        vectors += 5;
        if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_in_ready: got %b, required 1", bus.in_ready); end
        if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_out_valid: got %b, required 0", bus.out_valid); end
        if (bus.out_word !== 32'h0) begin miscompares++; $display("FAIL midrst_out_word: got %h, required 0", bus.out_word); end
        if (sbox_en !== 1'b0) begin miscompares++; $display("FAIL midrst_sbox_en: got %b, required 0", sbox_en); end
        if (sbox_byte_o !== 8'h0) begin miscompares++; $display("FAIL midrst_sbox_byte_o: got %h, required 0", sbox_byte_o); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vectors++;
            if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_stale_valid: got %b, required 0", bus.out_valid); end
        end
        send_word(32'h0000_0053, 1'b0, 1'b0);
        while (!bus.out_valid && n < 60) begin @(negedge clk); n++; end
        vectors++;
        if (bus.out_word !== 32'h636363ED) begin
            miscompares++; $display("FAIL midrst_next_word: got %h, required 636363ed", bus.out_word);
        end
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin @(negedge clk); n++; end
    endtask

    task automatic test_latency();
        int unsigned n = 0;
        bus.out_ready = 1'b1;
        send_word(32'h0000_0001, 1'b0, 1'b0);
        while (!bus.out_valid && n < 60) begin @(negedge clk); n++; end
        vectors += 2;
        if (cyc + 1 - hs_edge !== 5 + LAT) begin
            miscompares++; $display("FAIL lat_rise: out_valid at cycle %0d, required %0d", cyc + 1 - hs_edge, 5 + LAT);
        end
        if (bus.out_word !== 32'h6363637C) begin
            miscompares++; $display("FAIL lat_word: got %h, required 6363637c", bus.out_word);
        end
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin @(negedge clk); n++; end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++; $display("FAIL final_drain: %0d pending, required 0", exp_q.size());
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_word   = '0;
        bus.out_ready = 1'b0;
`ifdef SBOX_SEQ_ROTWORD_EN
        rot_en = 1'b0;
`endif
        test_reset();
        test_basic();
`ifdef SBOX_SEQ_ROTWORD_EN
        test_rotword();
`endif
        test_hold();
        test_back_to_back();
        test_reset_mid();
        test_latency();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
